pulse_bram_reader: RTL and testbench
====================================

Name: pulse_bram_reader

Overview:
- Consumer end of the pulse accumulation BRAM. The pulse generators read-modify-write IEEE-754 fp32 pulse shapes into this BRAM.
- This block sweeps the BRAM sequentially, one word address per sample, and streams each fp32 word out on a valid/ready interface.
- When enabled, it clears each location to 0 after reading it, so the buffer behaves as a circular sample ring.
- It shares the BRAM port conventions of the generators: byte addressing, step 4, synchronous read with 1-cycle latency.

Parameters:
- DEPTH, 2064, number of 32-bit words swept (covers an 11-bit random start plus 13 pulse taps); pointer wraps from DEPTH-1 to 0.
- ADDR_STEP, 4, byte increment between consecutive words on bram_addr.
- LAP_W, 16, width of lap_count.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = keep sweeping; 0 = finish current sample then idle.
- clear_en  in  1  1 = write 0 back to each word after it is read; sampled in the CAPT state.
- bram_addr  out  32  byte address = rd_ptr*ADDR_STEP.
- bram_data_in  out  32  write data; always 0 when written by this block.
- ena  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- bram_data_out  in  32  BRAM read data, valid the cycle after the edge that sampled ena=1 with bram_we=0.
- sample_data  out  32  fp32 word read from BRAM.
- sample_valid  out  1  sample_data holds an untransferred sample.
- sample_ready  in  1  downstream accepts sample_data when sample_valid and sample_ready are both high at a posedge.
- sample_index  out  32  word index (rd_ptr) of the sample currently on sample_data.
- wrap  out  1  1-cycle pulse on the transfer of the word at index DEPTH-1.
- lap_count  out  LAP_W  number of completed sweeps; wraps modulo 2^LAP_W.

Behaviour:
- Reset (async, immediate): all outputs 0, including bram_addr, bram_data_in, ena, bram_we, sample_data, sample_valid, sample_index, wrap and lap_count. rd_ptr=0, state=IDLE.
- Reset mid-operation abandons the sample in flight. The next sweep starts at index 0. An interrupted clear may leave that word uncleared; this is accepted.
- All outputs are registered. States: IDLE, WAIT, CAPT, HOLD.
- IDLE:
  - ena=0, bram_we=0.
  - If run=1: bram_addr<=rd_ptr*ADDR_STEP, ena<=1, bram_we<=0, go to WAIT.
- WAIT:
  - ena<=0; the BRAM samples the read at this edge. Go to CAPT.
- CAPT:
  - sample_data<=bram_data_out, sample_index<=rd_ptr, sample_valid<=1.
  - If clear_en=1: bram_data_in<=0, bram_we<=1, ena<=1, with bram_addr unchanged (same word).
  - Go to HOLD.
- HOLD:
  - ena<=0, bram_we<=0.
  - If sample_valid&sample_ready: this edge is the transfer. sample_valid<=0, and rd_ptr advances: if rd_ptr==DEPTH-1 then rd_ptr<=0, wrap<=1, lap_count<=lap_count+1; else rd_ptr<=rd_ptr+1.
  - After a transfer with run=1: bram_addr<=next_ptr*ADDR_STEP, ena<=1, go to WAIT (back-to-back).
  - After a transfer with run=0: go to IDLE.
  - With no transfer: stay in HOLD, keeping sample_data and sample_index stable.
- wrap is high for exactly the cycle after the wrapping transfer edge; otherwise 0.
- Latency: from IDLE with run rising, sample_valid goes high 3 edges later. Sustained throughput with sample_ready=1 is 1 sample per 3 cycles (WAIT, CAPT, HOLD).
- sample_valid never drops without a transfer; sample_ready is ignored outside HOLD.
- The clear write always completes (in the HOLD cycle) before the next read of any address.
- run=0 in any state other than IDLE does not abort: the current word is read, cleared if clear_en=1, and handed off before IDLE.
- run toggling in HOLD only matters at the transfer edge.
- sample_data is passed through bit-exact; no fp interpretation is done.
- Concurrent generator access to the BRAM is outside this block's scope; the system arbitrates the port.

Test Plan:
- Preload word k = k+1 (k=0..4), clear_en=1, sample_ready=1, run=1: sample_data sequence 1,2,3,4,5 with sample_index 0..4. Successive valid samples are 3 cycles apart; BRAM words 0..4 read back as 0 afterwards.
- clear_en=0, same preload, two sweeps: the second sweep returns the same values. wrap pulses once per sweep at index DEPTH-1; lap_count goes 1 then 2.
- Backpressure: sample_ready low for 10 cycles while sample_valid=1. sample_data and sample_index stay stable and no BRAM access occurs; the transfer happens on the first edge with ready=1.
- run dropped in CAPT: that sample is still presented and transferred, then the block goes to IDLE with ena=0. Raising run resumes at the next index.
- Async rst asserted mid-HOLD at index 7: outputs go to 0 immediately. After release with run=1, the first sample_index is 0.
- Preload word 3 with fp32 0x3E99652C and stream with clear_en=1: the sample at index 3 equals 0x3E99652C exactly, and word 3 reads back as 0.

Source files
------------

// File: rtl/pulse_bram_reader.sv
// ---------------------------------------------------------------------------
// pulse_bram_reader
//
// Consumer end of the pulse accumulation BRAM. The pulse generators
// read-modify-write fp32 pulse shapes into the BRAM. This block walks the
// BRAM one word at a time and streams each word out over a valid/ready
// handshake. When clear-on-read is enabled, each word is written back to 0
// once it has been captured, so the BRAM behaves as a circular sample ring.
//
// BRAM port conventions match the generators:
//   - byte addressing, ADDR_STEP bytes per word
//   - synchronous read with one cycle of latency
//
// Ports
//   i_clk            system clock, everything on the rising edge
//   i_rst            asynchronous active-high reset
//   i_run            1 = keep sweeping, 0 = finish current sample then idle
//   i_clear_en       1 = write 0 back to each word after reading (sampled in CAPT)
//   o_bram_addr      BRAM byte address (word pointer * ADDR_STEP)
//   o_bram_data_in   BRAM write data, always 0
//   o_ena            BRAM enable
//   o_bram_we        BRAM write enable
//   i_bram_data_out  BRAM read data
//   o_sample_data    fp32 word read from the BRAM, passed through bit-exact
//   o_sample_valid   o_sample_data holds a sample not yet transferred
//   i_sample_ready   downstream accepts the sample when valid & ready at a clock edge
//   o_sample_index   word index of the sample on o_sample_data
//   o_wrap           one-cycle pulse after the transfer of word DEPTH-1
//   o_lap_count      number of completed sweeps, modulo 2^LAP_W
// ---------------------------------------------------------------------------
module pulse_bram_reader #(
    parameter int DEPTH     = 2064,
    parameter int ADDR_STEP = 4,
    parameter int LAP_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_clear_en,
    output logic [31:0]      o_bram_addr,
    output logic [31:0]      o_bram_data_in,
    output logic             o_ena,
    output logic             o_bram_we,
    input  logic [31:0]      i_bram_data_out,
    output logic [31:0]      o_sample_data,
    output logic             o_sample_valid,
    input  logic             i_sample_ready,
    output logic [31:0]      o_sample_index,
    output logic             o_wrap,
    output logic [LAP_W-1:0] o_lap_count
);

    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [31:0]       STEP     = 32'(ADDR_STEP);

    // WAIT is the cycle in which the BRAM registers the read; CAPT grabs the
    // data and optionally issues the clear write; HOLD waits for the handshake.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPT,
        ST_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;

    logic [PTR_W-1:0]   r_rdPtr;
    logic [31:0]        r_bramAddr;
    logic [31:0]        r_bramDataIn;
    logic               r_ena;
    logic               r_bramWe;
    logic [31:0]        r_sampleData;
    logic               r_sampleValid;
    logic [31:0]        r_sampleIndex;
    logic               r_wrap;
    logic [LAP_W-1:0]   r_lapCount;

    logic [PTR_W-1:0]   w_rdPtr;
    logic [PTR_W-1:0]   w_nextPtr;
    logic               w_isLast;
    logic [31:0]        w_bramAddr;
    logic [31:0]        w_bramDataIn;
    logic               w_ena;
    logic               w_bramWe;
    logic [31:0]        w_sampleData;
    logic               w_sampleValid;
    logic [31:0]        w_sampleIndex;
    logic               w_wrap;
    logic [LAP_W-1:0]   w_lapCount;

    // Word pointer to byte address on the BRAM port.
    function automatic logic [31:0] f_byteAddr(input logic [PTR_W-1:0] ptr);
        return 32'(ptr) * STEP;
    endfunction

    // Pointer successor with wrap from the last word back to word 0.
    always_comb begin
        w_isLast  = (r_rdPtr == LAST_PTR);
        w_nextPtr = w_isLast ? '0 : r_rdPtr + PTR_W'(1);
    end

    // Next-state and next-output logic. Enable, write enable and wrap are
    // single-cycle strobes, so they default low; everything else holds.
    // A transfer only happens in HOLD, which keeps the ring pointer, lap
    // counter and wrap pulse tied to the handshake rather than to the read.
    always_comb begin
        w_stateNext   = r_state;
        w_rdPtr       = r_rdPtr;
        w_bramAddr    = r_bramAddr;
        w_bramDataIn  = 32'd0;
        w_ena         = 1'b0;
        w_bramWe      = 1'b0;
        w_sampleData  = r_sampleData;
        w_sampleValid = r_sampleValid;
        w_sampleIndex = r_sampleIndex;
        w_wrap        = 1'b0;
        w_lapCount    = r_lapCount;

        case (r_state)
            ST_IDLE: begin
                if (i_run) begin
                    w_bramAddr  = f_byteAddr(r_rdPtr);
                    w_ena       = 1'b1;
                    w_stateNext = ST_WAIT;
                end
            end

            ST_WAIT: begin
                w_stateNext = ST_CAPT;
            end

            ST_CAPT: begin
                w_sampleData  = i_bram_data_out;
                w_sampleIndex = 32'(r_rdPtr);
                w_sampleValid = 1'b1;
                // The clear reuses the address of the word just read, so it
                // lands in the HOLD cycle, ahead of any following read.
                if (i_clear_en) begin
                    w_bramWe = 1'b1;
                    w_ena    = 1'b1;
                end
                w_stateNext = ST_HOLD;
            end

            ST_HOLD: begin
                if (r_sampleValid && i_sample_ready) begin
                    w_sampleValid = 1'b0;
                    w_rdPtr       = w_nextPtr;
                    if (w_isLast) begin
                        w_wrap     = 1'b1;
                        w_lapCount = r_lapCount + LAP_W'(1);
                    end
                    if (i_run) begin
                        w_bramAddr  = f_byteAddr(w_nextPtr);
                        w_ena       = 1'b1;
                        w_stateNext = ST_WAIT;
                    end else begin
                        w_stateNext = ST_IDLE;
                    end
                end
            end

            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset abandons any sample in flight and
    // restarts the sweep at word 0; a clear interrupted by reset is not
    // retried.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_rdPtr       <= '0;
            r_bramAddr    <= 32'd0;
            r_bramDataIn  <= 32'd0;
            r_ena         <= 1'b0;
            r_bramWe      <= 1'b0;
            r_sampleData  <= 32'd0;
            r_sampleValid <= 1'b0;
            r_sampleIndex <= 32'd0;
            r_wrap        <= 1'b0;
            r_lapCount    <= '0;
        end else begin
            r_state       <= w_stateNext;
            r_rdPtr       <= w_rdPtr;
            r_bramAddr    <= w_bramAddr;
            r_bramDataIn  <= w_bramDataIn;
            r_ena         <= w_ena;
            r_bramWe      <= w_bramWe;
            r_sampleData  <= w_sampleData;
            r_sampleValid <= w_sampleValid;
            r_sampleIndex <= w_sampleIndex;
            r_wrap        <= w_wrap;
            r_lapCount    <= w_lapCount;
        end
    end

    assign o_bram_addr    = r_bramAddr;
    assign o_bram_data_in = r_bramDataIn;
    assign o_ena          = r_ena;
    assign o_bram_we      = r_bramWe;
    assign o_sample_data  = r_sampleData;
    assign o_sample_valid = r_sampleValid;
    assign o_sample_index = r_sampleIndex;
    assign o_wrap         = r_wrap;
    assign o_lap_count    = r_lapCount;

endmodule

// File: tb/tb_pulse_bram_reader.sv
// ---------------------------------------------------------------------------
// tb_pulse_bram_reader
//
// Self-checking bench for pulse_bram_reader. A behavioural BRAM with a
// one-cycle synchronous read sits on the DUT's BRAM port. Each scenario
// preloads the BRAM, pushes the samples it expects onto a scoreboard queue,
// and pops/compares as transfers happen.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pulse_bram_reader;

    localparam int DEPTH = 2064;
    localparam int LAP_W = 16;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] idx;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b0;
    logic             clearEn = 1'b0;
    logic [31:0]      bramAddr;
    logic [31:0]      bramDataIn;
    logic             ena;
    logic             bramWe;
    logic [31:0]      bramDout = 32'd0;
    logic [31:0]      sampleData;
    logic             sampleValid;
    logic             sampleReady = 1'b0;
    logic [31:0]      sampleIndex;
    logic             wrap;
    logic [LAP_W-1:0] lapCount;

    logic [31:0] mem [0:DEPTH-1];
    logic        tbWrEn = 1'b0;
    logic        tbClrAll = 1'b0;
    int          tbWrAddr = 0;
    logic [31:0] tbWrData = 32'd0;

    int cycleCount = 0;
    int accessCount = 0;
    int wrapHighCount = 0;

    int nCompared = 0;
    int nMismatched = 0;

    exp_t sb[$];

    pulse_bram_reader #(
        .DEPTH(DEPTH),
        .ADDR_STEP(4),
        .LAP_W(LAP_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_run(run),
        .i_clear_en(clearEn),
        .o_bram_addr(bramAddr),
        .o_bram_data_in(bramDataIn),
        .o_ena(ena),
        .o_bram_we(bramWe),
        .i_bram_data_out(bramDout),
        .o_sample_data(sampleData),
        .o_sample_valid(sampleValid),
        .i_sample_ready(sampleReady),
        .o_sample_index(sampleIndex),
        .o_wrap(wrap),
        .o_lap_count(lapCount)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: one-cycle synchronous read, write when we=1. The
    // bench preload/clear ports take priority and are only used while the
    // DUT is idle. Every DUT-enabled cycle is counted as an access.
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
        if (tbClrAll) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= 32'd0;
        end else if (tbWrEn) begin
            mem[tbWrAddr] <= tbWrData;
        end else if (ena === 1'b1) begin
            accessCount <= accessCount + 1;
            if (int'(bramAddr >> 2) < DEPTH) begin
                if (bramWe === 1'b1) mem[int'(bramAddr >> 2)] <= bramDataIn;
                else                 bramDout <= mem[int'(bramAddr >> 2)];
            end else if (bramWe !== 1'b1) begin
                bramDout <= 32'hDEAD_BEEF;
            end
        end
    end

    // Counts every cycle the wrap pulse is seen high.
    always @(negedge clk) begin
        if (wrap === 1'b1) wrapHighCount <= wrapHighCount + 1;
    end

    task automatic applyStimulus(input logic runV, input logic clearV, input logic readyV);
        run         = runV;
        clearEn     = clearV;
        sampleReady = readyV;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clearMem();
        @(negedge clk);
        tbClrAll = 1'b1;
        @(negedge clk);
        tbClrAll = 1'b0;
    endtask

    task automatic pokeWord(input int k, input logic [31:0] v);
        @(negedge clk);
        tbWrEn   = 1'b1;
        tbWrAddr = k;
        tbWrData = v;
        @(negedge clk);
        tbWrEn = 1'b0;
    endtask

    // Waits (bounded) for a negedge where valid is high, and ready too when
    // needReady is set. Returns with the next rising edge being the transfer.
    task automatic waitEvent(input int budget, input bit needReady,
                             output logic [31:0] data, output logic [31:0] idx,
                             output int atCycle, output bit timedOut);
        timedOut = 1'b1;
        data     = 32'd0;
        idx      = 32'd0;
        atCycle  = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (sampleValid === 1'b1 && (!needReady || sampleReady === 1'b1)) begin
                data     = sampleData;
                idx      = sampleIndex;
                atCycle  = cycleCount;
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [147:0] outs;
        @(negedge clk);
        outs = {bramAddr, bramDataIn, ena, bramWe, sampleData, sampleValid,
                sampleIndex, wrap, lapCount};
        nCompared++;
        if (outs !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: got %h, expected all zero", outs);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        nCompared++;
        if ({ena, sampleValid} !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL idle_without_run: ena/valid got %b, expected 00", {ena, sampleValid});
        end
    endtask

    task automatic test_stream_clear();
        logic [31:0] d, ix;
        int cyc, prevCyc, c0;
        bit tmo;
        exp_t e;
        doReset();
        clearMem();
        for (int k = 0; k < 5; k++) begin
            pokeWord(k, 32'(k + 1));
            sb.push_back('{data: 32'(k + 1), idx: 32'(k)});
        end
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1);
        c0 = cycleCount;
        prevCyc = c0;
        for (int i = 0; i < 5; i++) begin
            waitEvent(20, 1'b1, d, ix, cyc, tmo);
            if (tmo) begin
                nCompared++; nMismatched++;
                $display("[TB] FAIL stream_timeout: sample %0d never arrived", i);
                sb.delete();
                break;
            end
            if (i == 4) run = 1'b0;
            e = sb.pop_front();
            nCompared++;
            if ({d, ix} !== {e.data, e.idx}) begin
                nMismatched++;
                $display("[TB] FAIL stream_sample: got data %h idx %0d, expected data %h idx %0d",
                         d, ix, e.data, e.idx);
            end
            nCompared++;
            if ((cyc - prevCyc) !== 3) begin
                nMismatched++;
                $display("[TB] FAIL stream_spacing: sample %0d got %0d cycles, expected 3", i, cyc - prevCyc);
            end
            prevCyc = cyc;
        end
        repeat (4) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            nCompared++;
            if (mem[k] !== 32'd0) begin
                nMismatched++;
                $display("[TB] FAIL stream_cleared: word %0d got %h, expected 0", k, mem[k]);
            end
        end
    endtask

    task automatic test_two_sweeps();
        logic [31:0] d, ix;
        int cyc, wrapStart, lapExp;
        bit tmo, expWrap;
        exp_t e;
        doReset();
        clearMem();
        for (int k = 0; k < 5; k++) pokeWord(k, 32'(k + 1));
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < DEPTH; k++)
                sb.push_back('{data: (k < 5) ? 32'(k + 1) : 32'd0, idx: 32'(k)});
        lapExp = 0;
        @(negedge clk);
        wrapStart = wrapHighCount;
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int s = 0; s < 2 * DEPTH; s++) begin
            waitEvent(12, 1'b1, d, ix, cyc, tmo);
            if (tmo) begin
                nCompared++; nMismatched++;
                $display("[TB] FAIL sweep_timeout: sample %0d never arrived", s);
                sb.delete();
                break;
            end
            if (s == 2 * DEPTH - 1) run = 1'b0;
            e = sb.pop_front();
            nCompared++;
            if ({d, ix} !== {e.data, e.idx}) begin
                nMismatched++;
                $display("[TB] FAIL sweep_sample: got data %h idx %0d, expected data %h idx %0d",
                         d, ix, e.data, e.idx);
            end
            @(negedge clk);
            expWrap = (e.idx == 32'(DEPTH - 1));
            nCompared++;
            if (wrap !== expWrap) begin
                nMismatched++;
                $display("[TB] FAIL sweep_wrap: after idx %0d got %b, expected %b", e.idx, wrap, expWrap);
            end
            if (expWrap) begin
                lapExp++;
                nCompared++;
                if (lapCount !== LAP_W'(lapExp)) begin
                    nMismatched++;
                    $display("[TB] FAIL sweep_lap: got %0d, expected %0d", lapCount, lapExp);
                end
            end
        end
        repeat (3) @(negedge clk);
        nCompared++;
        if ((wrapHighCount - wrapStart) !== 2) begin
            nMismatched++;
            $display("[TB] FAIL sweep_wrap_count: got %0d pulses, expected 2", wrapHighCount - wrapStart);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d, ix;
        int cyc, snap;
        bit tmo, stable;
        exp_t e;
        doReset();
        clearMem();
        pokeWord(0, 32'hC0DE_0000);
        pokeWord(1, 32'hC0DE_0001);
        sb.push_back('{data: 32'hC0DE_0000, idx: 32'd0});
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitEvent(20, 1'b0, d, ix, cyc, tmo);
        if (tmo) begin
            nCompared++; nMismatched++;
            $display("[TB] FAIL bp_timeout: valid never rose");
            sb.delete();
            return;
        end
        @(negedge clk);
        snap = accessCount;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (sampleData !== d || sampleIndex !== ix || sampleValid !== 1'b1) stable = 1'b0;
        end
        nCompared++;
        if (!stable) begin
            nMismatched++;
            $display("[TB] FAIL bp_stable: got data %h idx %0d valid %b, expected data %h idx %0d valid 1",
                     sampleData, sampleIndex, sampleValid, d, ix);
        end
        nCompared++;
        if (accessCount !== snap) begin
            nMismatched++;
            $display("[TB] FAIL bp_no_access: got %0d accesses, expected 0", accessCount - snap);
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        nCompared++;
        if (sampleValid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL bp_transfer: valid got %b one edge after ready, expected 0", sampleValid);
        end
        e = sb.pop_front();
        nCompared++;
        if ({d, ix} !== {e.data, e.idx}) begin
            nMismatched++;
            $display("[TB] FAIL bp_sample: got data %h idx %0d, expected data %h idx %0d", d, ix, e.data, e.idx);
        end
        nCompared++;
        if (mem[0] !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL bp_cleared: word 0 got %h, expected 0", mem[0]);
        end
    endtask

    task automatic test_run_drop();
        logic [31:0] d, ix;
        int cyc, snap;
        bit tmo;
        exp_t e;
        doReset();
        clearMem();
        for (int k = 0; k < 4; k++) pokeWord(k, 32'h0000_0100 + 32'(k));
        sb.push_back('{data: 32'h0000_0100, idx: 32'd0});
        sb.push_back('{data: 32'h0000_0101, idx: 32'd1});
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        run = 1'b0;
        waitEvent(10, 1'b1, d, ix, cyc, tmo);
        e = sb.pop_front();
        nCompared++;
        if (tmo || {d, ix} !== {e.data, e.idx}) begin
            nMismatched++;
            $display("[TB] FAIL drop_sample: got data %h idx %0d (timeout %b), expected data %h idx %0d",
                     d, ix, tmo, e.data, e.idx);
        end
        @(negedge clk);
        snap = accessCount;
        repeat (5) @(negedge clk);
        nCompared++;
        if ({ena, sampleValid} !== 2'b00 || accessCount !== snap) begin
            nMismatched++;
            $display("[TB] FAIL drop_idle: ena/valid got %b accesses %0d, expected 00 and 0",
                     {ena, sampleValid}, accessCount - snap);
        end
        run = 1'b1;
        waitEvent(10, 1'b1, d, ix, cyc, tmo);
        run = 1'b0;
        e = sb.pop_front();
        nCompared++;
        if (tmo || {d, ix} !== {e.data, e.idx}) begin
            nMismatched++;
            $display("[TB] FAIL drop_resume: got data %h idx %0d (timeout %b), expected data %h idx %0d",
                     d, ix, tmo, e.data, e.idx);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [31:0] d, ix;
        int cyc;
        bit tmo;
        logic [147:0] outs;
        exp_t e;
        doReset();
        clearMem();
        for (int k = 0; k < 9; k++) begin
            pokeWord(k, 32'h0000_7000 + 32'(k));
            sb.push_back('{data: 32'h0000_7000 + 32'(k), idx: 32'(k)});
        end
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            waitEvent(12, i < 7, d, ix, cyc, tmo);
            if (tmo) begin
                nCompared++; nMismatched++;
                $display("[TB] FAIL ar_timeout: sample %0d never arrived", i);
                sb.delete();
                return;
            end
            e = sb.pop_front();
            nCompared++;
            if ({d, ix} !== {e.data, e.idx}) begin
                nMismatched++;
                $display("[TB] FAIL ar_sample: got data %h idx %0d, expected data %h idx %0d",
                         d, ix, e.data, e.idx);
            end
            if (i < 7) begin
                @(negedge clk);
                if (i == 6) sampleReady = 1'b0;
            end
        end
        sb.delete();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        outs = {bramAddr, bramDataIn, ena, bramWe, sampleData, sampleValid,
                sampleIndex, wrap, lapCount};
        nCompared++;
        if (outs !== '0) begin
            nMismatched++;
            $display("[TB] FAIL ar_immediate: got %h, expected all zero", outs);
        end
        sb.push_back('{data: 32'h0000_7000, idx: 32'd0});
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitEvent(12, 1'b1, d, ix, cyc, tmo);
        run = 1'b0;
        e = sb.pop_front();
        nCompared++;
        if (tmo || {d, ix} !== {e.data, e.idx}) begin
            nMismatched++;
            $display("[TB] FAIL ar_restart: got data %h idx %0d (timeout %b), expected data %h idx %0d",
                     d, ix, tmo, e.data, e.idx);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fp32_exact();
        logic [31:0] d, ix;
        int cyc;
        bit tmo;
        exp_t e;
        logic [31:0] vals [0:3];
        vals[0] = 32'h1111_1111;
        vals[1] = 32'h2222_2222;
        vals[2] = 32'hBF80_0000;
        vals[3] = 32'h3E99_652C;
        doReset();
        clearMem();
        for (int k = 0; k < 4; k++) begin
            pokeWord(k, vals[k]);
            sb.push_back('{data: vals[k], idx: 32'(k)});
        end
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            waitEvent(12, 1'b1, d, ix, cyc, tmo);
            if (tmo) begin
                nCompared++; nMismatched++;
                $display("[TB] FAIL fp_timeout: sample %0d never arrived", i);
                sb.delete();
                return;
            end
            if (i == 3) run = 1'b0;
            e = sb.pop_front();
            nCompared++;
            if ({d, ix} !== {e.data, e.idx}) begin
                nMismatched++;
                $display("[TB] FAIL fp_sample: got data %h idx %0d, expected data %h idx %0d",
                         d, ix, e.data, e.idx);
            end
        end
        repeat (4) @(negedge clk);
        nCompared++;
        if (mem[3] !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL fp_cleared: word 3 got %h, expected 0", mem[3]);
        end
    endtask

    initial begin
        $display("[TB] starting pulse_bram_reader bench");
        test_reset();
        test_stream_clear();
        test_two_sweeps();
        test_backpressure();
        test_run_drop();
        test_async_reset();
        test_fp32_exact();
        nCompared++;
        if (sb.size() !== 0) begin
            nMismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
